aes_stream_adapter: RTL and testbench
=====================================

# aes_stream_adapter

Word-stream front/back end for the AES_128 iterative core. Collects four 32-bit input words into a 128-bit block and latches key and direction. Arms the core by pulsing its reset, waits for `done`, then returns the result as four 32-bit output words over valid/ready. Optional CBC chaining sits between the stream and the core.

## Interface
- `WAIT_LIMIT`, 255: max cycles in RUN without `core_done_i` before abort (8-bit counter, 1..255).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `key_i` in 128: cipher key, sampled on first word of a block.
- `inv_i` in 1: 0 encrypt, 1 decrypt, sampled on first word of a block.
- `iv_i` in 128: CBC initial vector (CBC build only).
- `iv_load_i` in 1: load `iv_i` into chain register (CBC build only).
- `s_valid_i` in 1, `s_ready_o` out 1, `s_data_i` in 32: input word stream.
- `m_valid_o` out 1, `m_ready_i` in 1, `m_data_o` out 32: output word stream.
- `core_text_o` out 128, `core_key_o` out 128, `core_inv_o` out 1: core `input_text`, `master_key`, `inv_en`.
- `core_rst_n_o` out 1: drives core `rst_n`.
- `core_text_i` in 128, `core_done_i` in 1: core `output_text`, `done`.
- `busy_o` out 1: high in ARM, RUN, DRAIN.
- `err_o` out 1: sticky watchdog abort flag.

## Operation
- States: IDLE, LOAD, ARM, RUN, DRAIN. Reset state is IDLE.
- IDLE -> LOAD unconditionally, one cycle after reset release.
- LOAD:
  - `s_ready_o`=1. Words are accepted on `s_valid_i & s_ready_o`, MSW first: word0 -> [127:96] ... word3 -> [31:0]; 2-bit word counter.
  - On word0: latch `key_i` -> `core_key_o` and `inv_i` -> `core_inv_o`.
  - After word3: `core_text_o` <= assembled block (chained, see CBC); go to ARM.
- ARM: one cycle, `core_rst_n_o`=0 (registered). Core loads `core_text_o` and reset round. -> RUN.
- RUN:
  - Watchdog counts up from 0.
  - On `core_done_i`=1: capture the result into the output buffer; -> DRAIN.
  - Watchdog reaching `WAIT_LIMIT` with no done: set `err_o`, discard the block, -> LOAD.
  - `core_done_i` is ignored in all other states. The core free-runs after DONE and its output is never sampled.
- DRAIN:
  - `m_valid_o`=1, `m_data_o` = buffer word k, MSW first.
  - k advances on `m_valid_o & m_ready_i`; `m_data_o` is held stable while stalled.
  - After word3 is accepted -> LOAD. No overlap of input and output: `s_ready_o`=0 outside LOAD.
- Key and direction are fixed for the whole block. Changes on `key_i`/`inv_i` mid-block have no effect.

## Timing
- Reset values: `s_ready_o` 0, `m_valid_o` 0, `m_data_o` 0, `core_text_o` 0, `core_key_o` 0, `core_inv_o` 0, `core_rst_n_o` 0, `busy_o` 0, `err_o` 0, chain 0.
- `core_rst_n_o` rises on the first clock after `rst_n` release. Afterwards it is low only in ARM.
- Latency from word3 acceptance:
  - ARM on the next cycle.
  - RUN the cycle after ARM.
  - `m_valid_o` rises the cycle after `core_done_i` is sampled.
- Minimum throughput: 4 + 1 + core latency + 1 + 4 cycles per block.
- `core_inv_o`/`core_key_o` are stable at least 3 cycles before the ARM low pulse, as required because core round init depends on `inv_en` during reset.
- Reset mid-operation: all state returns to reset values immediately. A partially loaded or undrained block is lost.
- `err_o` is cleared only by `rst_n`.

## Configuration
- `AES_STREAM_CBC_EN` defined:
  - `iv_load_i` is honoured only in LOAD with word counter 0; it sets chain <= `iv_i`. If asserted on the same cycle as word0 acceptance, the IV load takes effect for that block.
  - Encrypt: `core_text_o` = block ^ chain. On done: output = `core_text_i`, chain <= `core_text_i`.
  - Decrypt: `core_text_o` = block. On done: output = `core_text_i` ^ chain, chain <= received ciphertext block.
  - A watchdog abort leaves chain unchanged.
- Not defined (ECB):
  - No chain register; `iv_i` and `iv_load_i` are unused.
  - `core_text_o` = block; output = `core_text_i`.

## Test plan
- ECB encrypt: key 000102030405060708090a0b0c0d0e0f, `inv_i`=0, words 00112233,44556677,8899aabb,ccddeeff -> `m_data_o` 69c4e0d8,6a7b0430,d8cdb780,70b4c55a; `core_rst_n_o` low for exactly 1 cycle.
- ECB decrypt: same key, `inv_i`=1, the ciphertext words above -> plaintext words 00112233..ccddeeff.
- Backpressure:
  - `s_valid_i` gapped 1-of-3 cycles and `m_ready_i` toggled -> identical output words, each `m_data_o` held while stalled.
  - `s_ready_o`=0 from ARM until DRAIN completes.
- Watchdog: `WAIT_LIMIT`=8 and `core_done_i` tied 0 -> `err_o`=1 exactly 8 cycles into RUN, state LOAD, `m_valid_o` never asserted.
- CBC (macro on): `iv_i`=00112233445566778899aabbccddeeff loaded, same plaintext and key -> output c6a13b37,878f5b82,6f4f8162,a1c8d879, and chain equals that value afterwards.
- Reset mid-DRAIN after word1 -> all outputs at reset values, next block processed correctly from word0.

Source files
------------

// File: rtl/aes_stream_adapter.sv
// aes_stream_adapter: 32-bit valid/ready word stream wrapper around the iterative AES_128 core.
// Collects four words into a block, pulses the core reset, waits for done, then streams the result.
// Optional CBC chaining is built when the macro AES_STREAM_CBC_EN is defined (ECB otherwise).
module aes_stream_adapter #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_i,
    input  logic         inv_i,
    input  logic [127:0] iv_i,
    input  logic         iv_load_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [31:0]  s_data_i,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic [31:0]  m_data_o,
    output logic [127:0] core_text_o,
    output logic [127:0] core_key_o,
    output logic         core_inv_o,
    output logic         core_rst_n_o,
    input  logic [127:0] core_text_i,
    input  logic         core_done_i,
    output logic         busy_o,
    output logic         err_o
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned WD_W   = 8;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WAIT_LIMIT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [1:0]        widx_q, widx_d;
    logic [1:0]        ridx_q, ridx_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [BLK_W-1:0]  obuf_q, obuf_d;
    logic [BLK_W-1:0]  text_q, text_d;
    logic [BLK_W-1:0]  key_q, key_d;
    logic              inv_q, inv_d;
    logic              s_ready_q, s_ready_d;
    logic              m_valid_q, m_valid_d;
    logic [WORD_W-1:0] m_data_q, m_data_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              s_accept, m_accept;
`ifdef AES_STREAM_CBC_EN
    logic [BLK_W-1:0]  chain_q, chain_d;
`else
    logic              unused_cbc;
    assign unused_cbc = ^{iv_i, iv_load_i};
`endif

    // Pick 32-bit word i of a block, word 0 being the most significant.
    function automatic logic [WORD_W-1:0] word_sel(input logic [BLK_W-1:0] b, input logic [1:0] i);
        case (i)
            2'd0:    word_sel = b[127:96];
            2'd1:    word_sel = b[95:64];
            2'd2:    word_sel = b[63:32];
            default: word_sel = b[31:0];
        endcase
    endfunction

    // Replace 32-bit word i of a block, word 0 being the most significant.
    function automatic logic [BLK_W-1:0] word_ins(input logic [BLK_W-1:0] b, input logic [1:0] i,
                                                  input logic [WORD_W-1:0] w);
        word_ins = b;
        case (i)
            2'd0:    word_ins[127:96] = w;
            2'd1:    word_ins[95:64]  = w;
            2'd2:    word_ins[63:32]  = w;
            default: word_ins[31:0]   = w;
        endcase
    endfunction

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d      = state_q;
        widx_d       = widx_q;
        ridx_d       = ridx_q;
        wd_d         = wd_q;
        blk_d        = blk_q;
        obuf_d       = obuf_q;
        text_d       = text_q;
        key_d        = key_q;
        inv_d        = inv_q;
        err_d        = err_q;
        m_data_d     = m_data_q;
`ifdef AES_STREAM_CBC_EN
        chain_d      = chain_q;
`endif
        s_accept     = s_valid_i & s_ready_q;
        m_accept     = m_valid_q & m_ready_i;

        unique case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
`ifdef AES_STREAM_CBC_EN
                if (iv_load_i && (widx_q == 2'd0)) chain_d = iv_i;
`endif
                if (s_accept) begin
                    blk_d  = word_ins(blk_q, widx_q, s_data_i);
                    widx_d = widx_q + 2'd1;
                    if (widx_q == 2'd0) begin
                        key_d = key_i;
                        inv_d = inv_i;
                    end
                    if (widx_q == 2'd3) begin
`ifdef AES_STREAM_CBC_EN
                        text_d = inv_q ? blk_d : (blk_d ^ chain_q);
`else
                        text_d = blk_d;
`endif
                        state_d = ARM;
                    end
                end
            end
            ARM: begin
                wd_d    = '0;
                state_d = RUN;
            end
            RUN: begin
                if (core_done_i) begin
`ifdef AES_STREAM_CBC_EN
                    if (inv_q) begin
                        obuf_d  = core_text_i ^ chain_q;
                        chain_d = blk_q;
                    end else begin
                        obuf_d  = core_text_i;
                        chain_d = core_text_i;
                    end
`else
                    obuf_d = core_text_i;
`endif
                    ridx_d  = 2'd0;
                    state_d = DRAIN;
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = LOAD;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            DRAIN: begin
                if (m_accept) begin
                    if (ridx_q == 2'd3) state_d = LOAD;
                    else                ridx_d  = ridx_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        s_ready_d    = (state_d == LOAD);
        m_valid_d    = (state_d == DRAIN);
        busy_d       = (state_d == ARM) || (state_d == RUN) || (state_d == DRAIN);
        core_rst_n_d = (state_d != ARM);
        if (state_d == DRAIN) m_data_d = word_sel(obuf_d, ridx_d);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            widx_q       <= '0;
            ridx_q       <= '0;
            wd_q         <= '0;
            blk_q        <= '0;
            obuf_q       <= '0;
            text_q       <= '0;
            key_q        <= '0;
            inv_q        <= 1'b0;
            s_ready_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef AES_STREAM_CBC_EN
            chain_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            ridx_q       <= ridx_d;
            wd_q         <= wd_d;
            blk_q        <= blk_d;
            obuf_q       <= obuf_d;
            text_q       <= text_d;
            key_q        <= key_d;
            inv_q        <= inv_d;
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
`ifdef AES_STREAM_CBC_EN
            chain_q      <= chain_d;
`endif
        end
    end

    assign s_ready_o    = s_ready_q;
    assign m_valid_o    = m_valid_q;
    assign m_data_o     = m_data_q;
    assign core_text_o  = text_q;
    assign core_key_o   = key_q;
    assign core_inv_o   = inv_q;
    assign core_rst_n_o = core_rst_n_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Testbench for aes_stream_adapter: behavioural stand-in core plus block-level reference model.
`timescale 1ns/1ps
module tb_aes_stream_adapter;
    localparam int unsigned WL = 8;
    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KAT_C0  = 128'hc6a13b37878f5b826f4f8162a1c8d879;
    localparam logic [127:0] KAT_IV  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [127:0] key_i = '0, iv_i = '0;
    logic         inv_i = 1'b0, iv_load_i = 1'b0;
    logic         s_valid_i = 1'b0, m_ready_i = 1'b0;
    logic [31:0]  s_data_i = '0;
    logic         s_ready_o, m_valid_o, core_inv_o, core_rst_n_o, busy_o, err_o;
    logic [31:0]  m_data_o;
    logic [127:0] core_text_o, core_key_o, core_text_i;
    logic         core_done_i;

    int n_checks = 0;
    int n_pass   = 0;

    aes_stream_adapter #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst_n(rst_n), .key_i(key_i), .inv_i(inv_i), .iv_i(iv_i), .iv_load_i(iv_load_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
        .core_text_o(core_text_o), .core_key_o(core_key_o), .core_inv_o(core_inv_o),
        .core_rst_n_o(core_rst_n_o), .core_text_i(core_text_i), .core_done_i(core_done_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Stand-in cipher: real AES answers for the known vectors, a cheap keyed mix otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [127:0] k, input logic inv);
        if (k == KAT_KEY) begin
            if (!inv && t == KAT_PT) return KAT_CT;
            if (!inv && t == '0)     return KAT_C0;
            if (inv && t == KAT_CT)  return KAT_PT;
            if (inv && t == KAT_C0)  return '0;
        end
        if (inv) return {t[100:0], t[127:101]} ^ k ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
        return t ^ {k[60:0], k[127:61]} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    endfunction

    // Stand-in core: latches its inputs while held in reset, raises done a programmable number of cycles later.
    int           core_lat = 3;
    bit           core_hang = 1'b0;
    int           fc_cnt = 0;
    logic         fc_done = 1'b0;
    logic [127:0] fc_res = '0;
    always @(posedge clk) begin
        if (!core_rst_n_o) begin
            fc_done <= 1'b0;
            fc_cnt  <= core_lat;
            fc_res  <= core_fn(core_text_o, core_key_o, core_inv_o);
        end else if (fc_cnt > 0 && !core_hang) begin
            fc_cnt <= fc_cnt - 1;
            if (fc_cnt == 1) fc_done <= 1'b1;
        end
    end
    assign core_text_i = fc_res;
    assign core_done_i = fc_done;

    // Block-level reference model (ECB, or CBC when the macro is set).
    logic [127:0] m_chain = '0;
    task automatic model_block(input logic [127:0] blk, input logic [127:0] key, input logic inv,
                               input bit iv_ld, input logic [127:0] iv,
                               output logic [127:0] exp_text, output logic [127:0] exp_out);
`ifdef AES_STREAM_CBC_EN
        if (iv_ld) m_chain = iv;
        if (!inv) begin
            exp_text = blk ^ m_chain;
            exp_out  = core_fn(exp_text, key, 1'b0);
            m_chain  = exp_out;
        end else begin
            exp_text = blk;
            exp_out  = core_fn(blk, key, 1'b1) ^ m_chain;
            m_chain  = blk;
        end
`else
        exp_text = blk;
        exp_out  = core_fn(blk, key, inv);
`endif
    endtask

    typedef struct {
        logic [127:0] got;
        logic [127:0] text;
        int           arm_lows;
        int           hold_viol;
        int           sready_viol;
        int           lat;
        logic         ready_after;
        bit           timeout;
    } obs_t;

    task automatic apply_reset();
        s_valid_i = 1'b0; m_ready_i = 1'b0; iv_load_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_chain = '0;
    endtask

    // Feed four words; returns at the negedge right after word3 was taken (the ARM cycle).
    task automatic send_words(input logic [127:0] blk, input logic [127:0] key, input logic inv,
                              input bit iv_ld, input logic [127:0] iv, input bit gapped, output bit timeout);
        int idx = 0;
        int guard = 0;
        while (idx < 4 && guard < 200) begin
            s_valid_i = gapped ? (($urandom % 3) == 0) : 1'b1;
            s_data_i  = blk[127 - 32*idx -: 32];
            if (idx == 0) begin
                key_i = key; inv_i = inv; iv_load_i = iv_ld; iv_i = iv;
            end else begin
                key_i = {$urandom, $urandom, $urandom, $urandom};
                inv_i = 1'($urandom);
                iv_load_i = 1'($urandom);
                iv_i = {$urandom, $urandom, $urandom, $urandom};
            end
            if (s_valid_i && s_ready_o) idx++;
            @(negedge clk);
            guard++;
        end
        s_valid_i = 1'b0; iv_load_i = 1'b0;
        timeout = (idx < 4);
    endtask

    // Run one block end to end and record what the DUT showed.
    task automatic do_block(input logic [127:0] blk, input logic [127:0] key, input logic inv,
                            input bit iv_ld, input logic [127:0] iv, input bit gapped, input bit stall,
                            output obs_t o);
        int k = 0;
        int cyc = 0;
        int done_at = -1;
        int valid_at = -1;
        logic [31:0] prev = '0;
        bit prev_stalled = 1'b0;
        o = '{default: '0};
        send_words(blk, key, inv, iv_ld, iv, gapped, o.timeout);
        o.text = core_text_o;
        while (k < 4 && cyc < 200) begin
            if (!core_rst_n_o) o.arm_lows++;
            if (s_ready_o) o.sready_viol++;
            if (cyc > 0 && core_done_i && done_at < 0) done_at = cyc;
            if (m_valid_o) begin
                if (valid_at < 0) valid_at = cyc;
                if (prev_stalled && m_data_o !== prev) o.hold_viol++;
                o.got[127 - 32*k -: 32] = m_data_o;
            end
            m_ready_i = stall ? 1'($urandom) : 1'b1;
            prev = m_data_o;
            prev_stalled = m_valid_o && !m_ready_i;
            if (m_valid_o && m_ready_i) k++;
            @(negedge clk);
            cyc++;
        end
        m_ready_i = 1'b0;
        if (k < 4) o.timeout = 1'b1;
        o.lat = valid_at - done_at;
        o.ready_after = s_ready_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_checks++;
        if ({s_ready_o, m_valid_o, m_data_o, core_text_o, core_key_o, core_inv_o, core_rst_n_o, busy_o, err_o} !== '0)
            $display("FAIL reset_values: outputs not all zero (s_ready=%b m_valid=%b core_rst_n=%b busy=%b err=%b)",
                     s_ready_o, m_valid_o, core_rst_n_o, busy_o, err_o);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (core_rst_n_o !== 1'b1) $display("FAIL core_rst_rise: got %b want 1", core_rst_n_o);
        else n_pass++;
        n_checks++;
        if (s_ready_o !== 1'b1) $display("FAIL load_after_reset: s_ready got %b want 1", s_ready_o);
        else n_pass++;
        m_chain = '0;
    endtask

    task automatic test_kat();
        obs_t o;
        logic [127:0] et, eo;
        apply_reset();
        core_lat = 4;
        model_block(KAT_PT, KAT_KEY, 1'b0, 1'b0, '0, et, eo);
        do_block(KAT_PT, KAT_KEY, 1'b0, 1'b0, '0, 1'b0, 1'b0, o);
        n_checks++;
        if (o.got !== KAT_CT) $display("FAIL kat_encrypt: got %h want %h", o.got, KAT_CT);
        else n_pass++;
        n_checks++;
        if (o.arm_lows !== 1) $display("FAIL arm_pulse_width: got %0d want 1", o.arm_lows);
        else n_pass++;
        n_checks++;
        if (o.lat !== 1) $display("FAIL done_to_valid: got %0d want 1", o.lat);
        else n_pass++;
        apply_reset();
        model_block(KAT_CT, KAT_KEY, 1'b1, 1'b0, '0, et, eo);
        do_block(KAT_CT, KAT_KEY, 1'b1, 1'b0, '0, 1'b1, 1'b1, o);
        n_checks++;
        if (o.got !== KAT_PT) $display("FAIL kat_decrypt: got %h want %h", o.got, KAT_PT);
        else n_pass++;
    endtask

    task automatic test_random_blocks();
        obs_t o;
        logic [127:0] blk, key, iv, et, eo;
        logic inv;
        bit iv_ld;
        for (int b = 0; b < 12; b++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            iv  = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom);
            iv_ld = (($urandom % 4) == 0);
            core_lat = 1 + int'($urandom % 5);
            model_block(blk, key, inv, iv_ld, iv, et, eo);
            do_block(blk, key, inv, iv_ld, iv, 1'($urandom), 1'($urandom), o);
            n_checks++;
            if (o.timeout) $display("FAIL rand_timeout[%0d]: block did not complete", b);
            else n_pass++;
            n_checks++;
            if (o.got !== eo) $display("FAIL rand_out[%0d]: got %h want %h", b, o.got, eo);
            else n_pass++;
            n_checks++;
            if (o.text !== et) $display("FAIL rand_core_text[%0d]: got %h want %h", b, o.text, et);
            else n_pass++;
            n_checks++;
            if (o.hold_viol !== 0 || o.sready_viol !== 0)
                $display("FAIL rand_handshake[%0d]: hold_viol %0d sready_viol %0d want 0 0", b, o.hold_viol, o.sready_viol);
            else n_pass++;
            n_checks++;
            if (o.ready_after !== 1'b1) $display("FAIL rand_back_to_load[%0d]: s_ready got %b want 1", b, o.ready_after);
            else n_pass++;
        end
    endtask

    task automatic test_watchdog();
        obs_t o;
        bit to;
        int err_at = -1;
        logic ready_at_err = 1'b0;
        bit mv = 1'b0;
        logic [127:0] blk, key, et, eo;
        apply_reset();
        core_hang = 1'b1;
        send_words({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                   1'b0, 1'b0, '0, 1'b0, to);
        for (int c = 0; c < 30; c++) begin
            if (m_valid_o) mv = 1'b1;
            if (err_o && err_at < 0) begin
                err_at = c;
                ready_at_err = s_ready_o;
            end
            @(negedge clk);
        end
        core_hang = 1'b0;
        n_checks++;
        if (err_at !== WL + 1) $display("FAIL wd_err_time: err seen %0d cycles after ARM want %0d", err_at, WL + 1);
        else n_pass++;
        n_checks++;
        if (ready_at_err !== 1'b1 || mv !== 1'b0)
            $display("FAIL wd_state: s_ready %b m_valid_seen %b want 1 0", ready_at_err, mv);
        else n_pass++;
        blk = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        core_lat = 2;
        model_block(blk, key, 1'b1, 1'b0, '0, et, eo);
        do_block(blk, key, 1'b1, 1'b0, '0, 1'b0, 1'b0, o);
        n_checks++;
        if (o.got !== eo) $display("FAIL wd_next_block: got %h want %h", o.got, eo);
        else n_pass++;
        n_checks++;
        if (err_o !== 1'b1) $display("FAIL wd_sticky: err got %b want 1", err_o);
        else n_pass++;
    endtask

`ifdef AES_STREAM_CBC_EN
    task automatic test_cbc();
        obs_t o;
        logic [127:0] et, eo;
        apply_reset();
        core_lat = 3;
        model_block(KAT_PT, KAT_KEY, 1'b0, 1'b1, KAT_IV, et, eo);
        do_block(KAT_PT, KAT_KEY, 1'b0, 1'b1, KAT_IV, 1'b1, 1'b0, o);
        n_checks++;
        if (o.got !== KAT_C0) $display("FAIL cbc_kat: got %h want %h", o.got, KAT_C0);
        else n_pass++;
        model_block('0, KAT_KEY, 1'b0, 1'b0, '0, et, eo);
        do_block('0, KAT_KEY, 1'b0, 1'b0, '0, 1'b0, 1'b0, o);
        n_checks++;
        if (o.text !== KAT_C0) $display("FAIL cbc_chain: core text got %h want %h", o.text, KAT_C0);
        else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_drain();
        obs_t o;
        bit to;
        int k = 0;
        int cyc = 0;
        logic [31:0] w0 = '0, w1 = '0;
        logic [127:0] blk, key, et, eo;
        apply_reset();
        blk = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        core_lat = 3;
        model_block(blk, key, 1'b0, 1'b0, '0, et, eo);
        send_words(blk, key, 1'b0, 1'b0, '0, 1'b0, to);
        while (k < 2 && cyc < 50) begin
            m_ready_i = 1'b1;
            if (m_valid_o) begin
                if (k == 0) w0 = m_data_o; else w1 = m_data_o;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        m_ready_i = 1'b0;
        n_checks++;
        if ({w0, w1} !== eo[127:64]) $display("FAIL mid_drain_words: got %h want %h", {w0, w1}, eo[127:64]);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s_ready_o, m_valid_o, m_data_o, core_text_o, core_key_o, core_inv_o, core_rst_n_o, busy_o, err_o} !== '0)
            $display("FAIL mid_drain_reset: outputs not zero (m_valid=%b m_data=%h busy=%b)", m_valid_o, m_data_o, busy_o);
        else n_pass++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_chain = '0;
        blk = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        model_block(blk, key, 1'b0, 1'b0, '0, et, eo);
        do_block(blk, key, 1'b0, 1'b0, '0, 1'b1, 1'b1, o);
        n_checks++;
        if (o.got !== eo) $display("FAIL after_reset_block: got %h want %h", o.got, eo);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_kat();
        test_random_blocks();
        test_watchdog();
`ifdef AES_STREAM_CBC_EN
        test_cbc();
`endif
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
